pipe_monitor: RTL and testbench
===============================

PIPE_MONITOR -- requirements
Module: pipe_monitor

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W, 32, width of each watched channel
  NCH, 2, number of watched channels (1..16)
  CNT_W, 32, width of the cycle and instruction counters
  DRAIN_CYC, 4, pipeline drain cycles after halt detection (1..15)
  HALT_WORD, 32'h0FC00000, instruction encoding that means halt
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state on rising edge
  reset  input  1  asynchronous, active-high reset
  clear  input  1  synchronous restart of all statistics
  instruction  input  32  fetched instruction word
  instr_valid  input  1  instruction is a real fetch this cycle
  ch_data  input  NCH*DATA_W  packed channel samples; channel i at bits [i*DATA_W +: DATA_W]
  ch_valid  input  NCH  per-channel sample strobe
  cycle_count  output  CNT_W  cycles spent in RUN plus DRAIN
  instr_count  output  CNT_W  valid instructions seen in RUN
  cnt_ovf  output  1  sticky flag; either counter saturated
  ch_min  output  NCH*DATA_W  per-channel minimum
  ch_max  output  NCH*DATA_W  per-channel maximum
  ch_seen  output  NCH  channel has at least one sample
  halt_req  output  1  one-cycle pulse on entry to DONE
  done  output  1  high while in DONE

Function
REQ-003 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-004 Transition IDLE->RUN SHALL occur on the first instr_valid; that cycle counts (cycle_count=1, instr_count=1 after the edge).
REQ-005 In RUN, cycle_count SHALL increment every cycle, and instr_count SHALL increment on each instr_valid.
REQ-006 In RUN, instr_valid with instruction==HALT_WORD SHALL count as an instruction, load the drain counter with DRAIN_CYC-1, and move the FSM to DRAIN.
REQ-007 DRAIN SHALL keep incrementing cycle_count, SHALL ignore instr_valid for instr_count, and SHALL keep updating min/max.
REQ-008 When the drain counter is 0 in DRAIN, the FSM SHALL go to DONE; halt_req SHALL pulse for exactly the first DONE cycle.
REQ-009 In DONE, all counters, min, max and seen SHALL be frozen, and done SHALL be 1.
REQ-010 Counters SHALL saturate at all-ones rather than wrap; saturation SHALL set cnt_ovf, which stays set until clear or reset.
REQ-011 In RUN and DRAIN, a channel's first ch_valid sample SHALL load both min and max and set ch_seen; later samples SHALL update min when smaller and max when larger.
REQ-012 Samples in IDLE or DONE SHALL be ignored.
REQ-013 clear in any state SHALL, on the next edge, move the FSM to IDLE and zero the counters, cnt_ovf, ch_min, ch_max and ch_seen.
REQ-014 clear SHALL take priority over halt detection and over the DRAIN->DONE transition in the same cycle.
REQ-015 A HALT_WORD seen in IDLE SHALL start RUN and enter DRAIN on the same edge.
REQ-016 Outputs SHALL be registered, with 1-cycle latency from input to visible statistic.

Reset
REQ-017 Asserting reset SHALL immediately force IDLE, with all counters, cnt_ovf, ch_min, ch_max, ch_seen, halt_req and done equal to 0.
REQ-018 Reset asserted mid-DRAIN SHALL abort the drain with no halt_req pulse.

Configuration
REQ-019 With MONITOR_SIGNED_EN defined, min/max comparison SHALL be two's-complement signed.
REQ-020 Without MONITOR_SIGNED_EN, min/max comparison SHALL be unsigned; no other behaviour SHALL change.

Structure
REQ-021 Package mon_pkg SHALL hold the FSM state typedef and the default HALT_WORD constant.
REQ-022 Per-channel min/max tracking SHALL be sub-module mon_minmax, instantiated NCH times with a generate loop.

Verification
REQ-023 Reset, then 10 valid instructions, then HALT_WORD, DRAIN_CYC=4 -> instr_count=11, cycle_count=15 in DONE, one halt_req pulse, done=1.
REQ-024 Channel 0 with MONITOR_SIGNED_EN gets samples 5, -3, 12, 0 -> ch_min=-3, ch_max=12; without the macro -> ch_min=0, ch_max=32'hFFFFFFFD.
REQ-025 CNT_W=4 with 20 RUN cycles -> cycle_count stays at 15 and cnt_ovf=1.
REQ-026 clear on the same cycle as the DRAIN->DONE transition -> FSM in IDLE, no halt_req, all statistics 0.
REQ-027 reset pulsed 2 cycles into DRAIN -> outputs 0 immediately and halt_req never asserted.
REQ-028 Channel 1 never strobed while channel 0 strobed -> ch_seen=2'b01 and ch_min/ch_max of channel 1 equal 0.

Source files
------------

// File: rtl/mon_pkg.sv
// rtl/mon_pkg.sv - shared types and constants for the pipeline monitor
// Holds the monitor FSM state type and the default halt instruction encoding.
package mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0FC0_0000;

endpackage

// File: rtl/mon_minmax.sv
// rtl/mon_minmax.sv - per-channel running minimum/maximum tracker
// Build option: MONITOR_SIGNED_EN selects two's-complement comparison
// (unsigned when undefined).
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset
//   i_clear  synchronous clear of min, max and seen
//   i_en     tracking window open (monitor in RUN or DRAIN)
//   i_valid  sample strobe
//   i_data   sample value
//   o_min    running minimum
//   o_max    running maximum
//   o_seen   at least one sample captured
module mon_minmax #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_min,
    output logic [DATA_W-1:0] o_max,
    output logic              o_seen
);

    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;
    logic              r_seen;
    logic              w_lt;
    logic              w_gt;

`ifdef MONITOR_SIGNED_EN
    assign w_lt = $signed(i_data) < $signed(r_min);
    assign w_gt = $signed(i_data) > $signed(r_max);
`else
    assign w_lt = i_data < r_min;
    assign w_gt = i_data > r_max;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_min  <= '0;
            r_max  <= '0;
            r_seen <= 1'b0;
        end else if (i_clear) begin
            r_min  <= '0;
            r_max  <= '0;
            r_seen <= 1'b0;
        end else if (i_en && i_valid) begin
            // The zero reset values are placeholders, so the first sample
            // must overwrite both bounds rather than be compared to them.
            if (!r_seen) begin
                r_min  <= i_data;
                r_max  <= i_data;
                r_seen <= 1'b1;
            end else begin
                if (w_lt) r_min <= i_data;
                if (w_gt) r_max <= i_data;
            end
        end
    end

    assign o_min  = r_min;
    assign o_max  = r_max;
    assign o_seen = r_seen;

endmodule

// File: rtl/pipe_monitor.sv
// rtl/pipe_monitor.sv - pipeline run monitor: cycle/instruction counters, halt drain, channel min/max
// Build option: MONITOR_SIGNED_EN makes channel min/max comparison signed.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   clear               synchronous restart of all statistics (returns to IDLE)
//   instruction         fetched instruction word
//   instr_valid         instruction is a real fetch this cycle
//   ch_data, ch_valid   packed channel samples and per-channel strobes
//   cycle_count         cycles spent in RUN plus DRAIN (saturating)
//   instr_count         valid instructions seen in RUN (saturating)
//   cnt_ovf             sticky: a counter tried to pass all-ones
//   ch_min, ch_max      per-channel running bounds
//   ch_seen             per-channel sample-captured flags
//   halt_req            one-cycle pulse on entry to DONE
//   done                high while in DONE
module pipe_monitor
    import mon_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          NCH       = 2,
    parameter int          CNT_W     = 32,
    parameter int          DRAIN_CYC = 4,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [31:0]           instruction,
    input  logic                  instr_valid,
    input  logic [NCH*DATA_W-1:0] ch_data,
    input  logic [NCH-1:0]        ch_valid,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      instr_count,
    output logic                  cnt_ovf,
    output logic [NCH*DATA_W-1:0] ch_min,
    output logic [NCH*DATA_W-1:0] ch_max,
    output logic [NCH-1:0]        ch_seen,
    output logic                  halt_req,
    output logic                  done
);

    localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    mon_state_t       r_state;
    mon_state_t       w_next;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_ins;
    logic [3:0]       r_drain;
    logic             r_ovf;
    logic             r_halt_req;
    logic             r_done;

    logic w_is_halt;
    logic w_cyc_inc;
    logic w_ins_inc;
    logic w_load_drain;
    logic w_ovf_hit;
    logic w_active;

    assign w_is_halt = instr_valid && (instruction == HALT_WORD);
    assign w_active  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_ovf_hit = (w_cyc_inc && (r_cyc == CNT_MAX)) ||
                       (w_ins_inc && (r_ins == CNT_MAX));

    always_comb begin
        w_next       = r_state;
        w_cyc_inc    = 1'b0;
        w_ins_inc    = 1'b0;
        w_load_drain = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The starting fetch is itself counted; a halt here both
                // starts and ends the run on the same edge.
                if (instr_valid) begin
                    w_cyc_inc    = 1'b1;
                    w_ins_inc    = 1'b1;
                    w_load_drain = w_is_halt;
                    w_next       = w_is_halt ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                w_cyc_inc = 1'b1;
                w_ins_inc = instr_valid;
                if (w_is_halt) begin
                    w_load_drain = 1'b1;
                    w_next       = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_cyc_inc = 1'b1;
                if (r_drain == 4'd0) w_next = ST_DONE;
            end
            default: begin
                w_next = ST_DONE;
            end
        endcase
        if (clear) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cyc      <= '0;
            r_ins      <= '0;
            r_drain    <= '0;
            r_ovf      <= 1'b0;
            r_halt_req <= 1'b0;
            r_done     <= 1'b0;
        end else if (clear) begin
            r_state    <= ST_IDLE;
            r_cyc      <= '0;
            r_ins      <= '0;
            r_drain    <= '0;
            r_ovf      <= 1'b0;
            r_halt_req <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cyc_inc && (r_cyc != CNT_MAX)) r_cyc <= r_cyc + CNT_W'(1);
            if (w_ins_inc && (r_ins != CNT_MAX)) r_ins <= r_ins + CNT_W'(1);
            r_ovf <= r_ovf | w_ovf_hit;
            if (w_load_drain)
                r_drain <= DRAIN_LOAD;
            else if ((r_state == ST_DRAIN) && (r_drain != 4'd0))
                r_drain <= r_drain - 4'd1;
            r_halt_req <= (r_state == ST_DRAIN) && (w_next == ST_DONE);
            r_done     <= (w_next == ST_DONE);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            mon_minmax #(
                .DATA_W(DATA_W)
            ) u_minmax (
                .i_clk   (clk),
                .i_reset (reset),
                .i_clear (clear),
                .i_en    (w_active),
                .i_valid (ch_valid[g]),
                .i_data  (ch_data[g*DATA_W +: DATA_W]),
                .o_min   (ch_min[g*DATA_W +: DATA_W]),
                .o_max   (ch_max[g*DATA_W +: DATA_W]),
                .o_seen  (ch_seen[g])
            );
        end
    endgenerate

    assign cycle_count = r_cyc;
    assign instr_count = r_ins;
    assign cnt_ovf     = r_ovf;
    assign halt_req    = r_halt_req;
    assign done        = r_done;

endmodule

// File: tb/tb_pipe_monitor.sv
// tb/tb_pipe_monitor.sv - directed self-checking bench for pipe_monitor
module tb_pipe_monitor;

    localparam logic [31:0] HALT = 32'h0FC0_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_valid = 1'b0;
    logic [63:0] ch_data = '0;
    logic [1:0]  ch_valid = '0;

    logic [31:0] cycle_count, instr_count;
    logic        cnt_ovf, halt_req, done;
    logic [63:0] ch_min, ch_max;
    logic [1:0]  ch_seen;

    logic [3:0]  s_cycle_count, s_instr_count;
    logic        s_cnt_ovf, s_halt_req, s_done;
    logic [63:0] s_ch_min, s_ch_max;
    logic [1:0]  s_ch_seen;

    int n_vec  = 0;
    int n_miss = 0;
    int n_halt = 0;

    logic [31:0] samp [4];

    pipe_monitor u_dut (
        .clk(clk), .reset(reset), .clear(clear),
        .instruction(instruction), .instr_valid(instr_valid),
        .ch_data(ch_data), .ch_valid(ch_valid),
        .cycle_count(cycle_count), .instr_count(instr_count), .cnt_ovf(cnt_ovf),
        .ch_min(ch_min), .ch_max(ch_max), .ch_seen(ch_seen),
        .halt_req(halt_req), .done(done)
    );

    pipe_monitor #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .clear(clear),
        .instruction(instruction), .instr_valid(instr_valid),
        .ch_data(ch_data), .ch_valid(ch_valid),
        .cycle_count(s_cycle_count), .instr_count(s_instr_count), .cnt_ovf(s_cnt_ovf),
        .ch_min(s_ch_min), .ch_max(s_ch_max), .ch_seen(s_ch_seen),
        .halt_req(s_halt_req), .done(s_done)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (halt_req) n_halt++;
    endtask

    task automatic apply_reset;
        reset       = 1'b1;
        clear       = 1'b0;
        instr_valid = 1'b0;
        ch_valid    = '0;
        tick;
        tick;
        reset  = 1'b0;
        n_halt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        samp[0] = 32'd5;
        samp[1] = 32'hFFFF_FFFD;
        samp[2] = 32'd12;
        samp[3] = 32'd0;

        // Reset state
        #2;
        check_vec("rst_cycle", 64'(cycle_count), 64'd0);
        check_vec("rst_instr", 64'(instr_count), 64'd0);
        check_vec("rst_flags", {61'd0, cnt_ovf, halt_req, done}, 64'd0);
        check_vec("rst_seen",  64'(ch_seen), 64'd0);
        apply_reset;

        // Normal run: 10 instructions, halt, 4 drain cycles
        for (int k = 1; k <= 10; k++) begin
            instruction = NOP;
            instr_valid = 1'b1;
            ch_valid    = '0;
            if (k >= 2 && k <= 5) begin
                ch_valid      = 2'b01;
                ch_data[31:0] = samp[k-2];
            end
            tick;
            if (k == 1) begin
                check_vec("start_cycle", 64'(cycle_count), 64'd1);
                check_vec("start_instr", 64'(instr_count), 64'd1);
            end
        end
        ch_valid    = '0;
        instruction = HALT;
        tick;
        check_vec("halt_instr", 64'(instr_count), 64'd11);
        check_vec("halt_cycle", 64'(cycle_count), 64'd11);
        instruction = NOP;
        repeat (3) tick;
        check_vec("drain_done", 64'(done), 64'd0);
        check_vec("drain_instr_ignored", 64'(instr_count), 64'd11);
        tick;
        check_vec("done_flag", 64'(done), 64'd1);
        check_vec("done_halt_req", 64'(halt_req), 64'd1);
        check_vec("done_cycle", 64'(cycle_count), 64'd15);
        ch_valid = 2'b11;
        ch_data  = {32'h8000_0000, 32'h8000_0000};
        tick;
        ch_valid = '0;
        check_vec("halt_req_pulse", 64'(halt_req), 64'd0);
        check_vec("done_held", 64'(done), 64'd1);
        check_vec("frozen_cycle", 64'(cycle_count), 64'd15);
        check_vec("frozen_instr", 64'(instr_count), 64'd11);
        check_vec("halt_pulses", 64'(n_halt), 64'd1);
`ifdef MONITOR_SIGNED_EN
        check_vec("ch0_min", 64'(ch_min[31:0]), 64'h0000_0000_FFFF_FFFD);
        check_vec("ch0_max", 64'(ch_max[31:0]), 64'd12);
`else
        check_vec("ch0_min", 64'(ch_min[31:0]), 64'd0);
        check_vec("ch0_max", 64'(ch_max[31:0]), 64'h0000_0000_FFFF_FFFD);
`endif
        check_vec("ch_seen", 64'(ch_seen), 64'd1);
        check_vec("ch1_min", 64'(ch_min[63:32]), 64'd0);
        check_vec("ch1_max", 64'(ch_max[63:32]), 64'd0);

        // Halt in IDLE, then clear on the DRAIN->DONE cycle
        apply_reset;
        instruction = HALT;
        instr_valid = 1'b1;
        tick;
        check_vec("idle_halt_cycle", 64'(cycle_count), 64'd1);
        check_vec("idle_halt_instr", 64'(instr_count), 64'd1);
        instr_valid     = 1'b0;
        ch_valid        = 2'b10;
        ch_data[63:32]  = 32'd7;
        tick;
        ch_valid = '0;
        tick;
        tick;
        check_vec("drain_seen", 64'(ch_seen), 64'd2);
        check_vec("drain_ch1_max", 64'(ch_max[63:32]), 64'd7);
        check_vec("drain_cycle", 64'(cycle_count), 64'd4);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        check_vec("clr_cycle", 64'(cycle_count), 64'd0);
        check_vec("clr_instr", 64'(instr_count), 64'd0);
        check_vec("clr_flags", {61'd0, cnt_ovf, halt_req, done}, 64'd0);
        check_vec("clr_seen", 64'(ch_seen), 64'd0);
        check_vec("clr_max", ch_max, 64'd0);
        tick;
        check_vec("clr_idle_cycle", 64'(cycle_count), 64'd0);
        check_vec("clr_no_halt", 64'(n_halt + int'(done)), 64'd0);

        // Reset two cycles into DRAIN
        apply_reset;
        instruction = HALT;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        check_vec("async_rst_cycle", 64'(cycle_count), 64'd0);
        check_vec("async_rst_instr", 64'(instr_count), 64'd0);
        check_vec("async_rst_flags", {61'd0, cnt_ovf, halt_req, done}, 64'd0);
        repeat (3) tick;
        reset = 1'b0;
        repeat (5) tick;
        check_vec("rst_abort_no_halt", 64'(n_halt), 64'd0);
        check_vec("rst_abort_done", 64'(done), 64'd0);

        // Saturation with a 4-bit counter instance
        apply_reset;
        instruction = NOP;
        instr_valid = 1'b1;
        repeat (20) tick;
        instr_valid = 1'b0;
        check_vec("sat_cycle", 64'(s_cycle_count), 64'd15);
        check_vec("sat_instr", 64'(s_instr_count), 64'd15);
        check_vec("sat_ovf", 64'(s_cnt_ovf), 64'd1);
        check_vec("wide_cycle", 64'(cycle_count), 64'd20);
        check_vec("wide_ovf", 64'(cnt_ovf), 64'd0);
        tick;
        check_vec("sat_ovf_sticky", 64'(s_cnt_ovf), 64'd1);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        check_vec("sat_ovf_clr", 64'(s_cnt_ovf), 64'd0);
        check_vec("sat_cycle_clr", 64'(s_cycle_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
